ring_input_vc_buffer: RTL and testbench
=======================================

// Module: ring_input_vc_buffer
// PURPOSE
//   Ring input stage of the router: accepts flits from the upstream neighbour's ring link (si/ri/di), sorts them into
//   even/odd virtual-channel FIFOs by the VC bit, and decodes the route of each head flit.
//   Raises per-VC requests to the ring output stage (forward) or to the PE output stage (eject), and holds the head
//   flit stable until granted. Directly feeds the ring output block's request/grant/data_in ports.
// PARAMETERS
//   DATA_WIDTH  64  flit width; field positions fixed for 64
//   DEPTH       2   entries per VC FIFO; power of two, >=2
//   CNT_W       8   width of drop counter (RING_IBUF_DROP_CNT_EN only)
// PORTS
//   clk            in   1           clock, all state updates on posedge
//   rst            in   1           synchronous, active-high reset
//   polarity       in   1           router phase; 0 = even VC phase, 1 = odd VC phase
//   si             in   1           upstream send strobe, flit valid on di
//   ri             out  1           ready to upstream for the VC of the current phase
//   di             in   DATA_WIDTH  incoming flit
//   req_ring_even  out  1           even head flit requests ring output (forward)
//   req_ring_odd   out  1           odd head flit requests ring output
//   req_pe_even    out  1           even head flit requests PE output (eject)
//   req_pe_odd     out  1           odd head flit requests PE output
//   grant_ring_even/grant_ring_odd/grant_pe_even/grant_pe_odd  in 1 each  grants from output stages
//   data_out_even  out  DATA_WIDTH  head of even FIFO
//   data_out_odd   out  DATA_WIDTH  head of odd FIFO
//   drop_cnt       out  CNT_W       flits dropped on full FIFO (0 without macro)
// BEHAVIOUR
//   Flit fields: [63] VC (0 even, 1 odd), [62] direction, [55:48] hop field. Hop field == 8'h00 -> eject (PE);
//     any other value -> forward (ring). Downstream ring output shifts hop right; this block never modifies flits.
//   ri = polarity ? ~full_odd : ~full_even, combinational from registered FIFO counts.
//   Capture: posedge with si=1 writes di into FIFO selected by di[63] if that FIFO is not full at cycle start;
//     if full, flit discarded, FIFOs unchanged, drop event raised.
//   Per-VC FSM (2 bits, package encodings): IDLE (FIFO empty, no request) -> REQ when count>0;
//     REQ: exactly one of req_ring_x/req_pe_x high, selected by head hop field; data_out_x = head, stable;
//     REQ -> POP on posedge sampling the matching grant_*_x=1 (grant of the non-requested class ignored);
//     POP: one cycle, requests low, read pointer advanced; -> REQ if count>0 else IDLE.
//   Grant may stay high several cycles; only the first sampled grant pops, POP guarantees request gap of 1 cycle.
//   Latency: flit captured at posedge t into empty FIFO -> request high after posedge t+1 (FSM registered).
//   Simultaneous push and pop on same VC in same cycle: both performed, count unchanged; full check uses
//     start-of-cycle count (no push into full FIFO even if popping).
//   Pointers wrap modulo DEPTH; count is DEPTH+1 states (0..DEPTH).
//   data_out_x holds last head value when FIFO empty (not cleared); requests 0 in that case.
//   Reset (any cycle, incl. mid-request): pointers/counts 0, FSMs IDLE, all req_* 0, data_out_* 0, drop_cnt 0;
//     ri = 1 in the cycle following reset release.
// CONFIGURATION
//   RING_IBUF_DROP_CNT_EN defined: drop_cnt increments by 1 per drop event, saturates at all-ones.
//   Not defined: counter logic absent, drop_cnt tied to 0; drops still discard silently.
// STRUCTURE
//   Shared package/header ring_pkg: flit field positions (VC_BIT, DIR_BIT, HOP_MSB/LSB), VC FSM encodings,
//     DATA_WIDTH default. Shared with ring output and PE stages.
//   Sub-module ring_ibuf_vc_fifo (DEPTH x DATA_WIDTH, push/pop/count/head), instantiated twice (even, odd);
//     top holds capture steering, route decode, two VC FSMs, ri mux, drop counter.
// TESTING
//   Even flit hop 8'h04 at polarity=0, si=1 -> req_ring_even=1 next cycle, data_out_even=flit; grant_ring_even 1 cycle
//     -> req_ring_even=0 one cycle, FIFO empty, ri=1.
//   Odd flit hop 8'h00 -> req_pe_odd=1, req_ring_odd=0; grant_ring_odd asserted -> no pop; grant_pe_odd -> pop.
//   Push 2 even flits, no grant -> ri=0 while polarity=0, ri=1 at polarity=1; 3rd even si -> dropped,
//     drop_cnt=1 (macro on) / 0 (off); grants drain flits in order 1,2.
//   Full even FIFO, simultaneous push and grant -> push dropped, pop done, count 1; grant held 3 cycles -> one pop only.
//   Interleaved even/odd traffic, 8 flits each, random grant delays 0-5 cycles -> per-VC order preserved, no loss.
//   rst asserted while req_ring_odd=1 with 2 flits queued -> next cycle all req_* 0, counts 0, ri=1, drop_cnt=0.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared ring router definitions: flit field positions, VC FSM encodings.
// Used by the ring input, ring output and PE stages.
package ring_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;

    localparam int VC_BIT  = 63;
    localparam int DIR_BIT = 62;
    localparam int HOP_MSB = 55;
    localparam int HOP_LSB = 48;
    localparam int HOP_W   = HOP_MSB - HOP_LSB + 1;

    typedef enum logic [1:0] {
        VC_IDLE = 2'b00,
        VC_REQ  = 2'b01,
        VC_POP  = 2'b10
    } vc_state_e;

    // A zero hop field means the flit has arrived and leaves via the PE.
    function automatic logic hop_is_eject(input logic [HOP_W-1:0] hop);
        return hop == '0;
    endfunction

endpackage

// File: rtl/ring_ibuf_vc_fifo.sv
// Per-VC flit FIFO for the ring input buffer (DEPTH x DATA_WIDTH).
// Caller guarantees no push when full and no pop when empty.
module ring_ibuf_vc_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt_q;

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count spans 0..DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ring_input_vc_buffer.sv
// Ring input stage: sorts upstream flits into even/odd VC FIFOs and requests forward/eject.
// Optional drop counter enabled with `define RING_IBUF_DROP_CNT_EN.
module ring_input_vc_buffer
    import ring_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  si,
    output logic                  ri,
    input  logic [DATA_WIDTH-1:0] di,
    output logic                  req_ring_even,
    output logic                  req_ring_odd,
    output logic                  req_pe_even,
    output logic                  req_pe_odd,
    input  logic                  grant_ring_even,
    input  logic                  grant_ring_odd,
    input  logic                  grant_pe_even,
    input  logic                  grant_pe_odd,
    output logic [DATA_WIDTH-1:0] data_out_even,
    output logic [DATA_WIDTH-1:0] data_out_odd,
    output logic [CNT_W-1:0]      drop_cnt
);

    localparam int FCNT_W = $clog2(DEPTH + 1);

    logic                  in_vc;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            full;
    logic [1:0]            gnt_ring;
    logic [1:0]            gnt_pe;
    logic [FCNT_W-1:0]     count [2];
    logic [DATA_WIDTH-1:0] head  [2];

    vc_state_e             state    [2];
    logic [DATA_WIDTH-1:0] head_q   [2];
    logic [1:0]            req_ring_q;
    logic [1:0]            req_pe_q;
    logic [1:0]            gnt_seen;

    assign in_vc    = di[VC_BIT];
    assign gnt_ring = {grant_ring_odd, grant_ring_even};
    assign gnt_pe   = {grant_pe_odd, grant_pe_even};

    // Steer an incoming flit to its VC; a full VC (start of cycle) refuses it.
    always_comb begin
        push = '0;
        if (si && !full[in_vc]) begin
            push[in_vc] = 1'b1;
        end
    end

    // Pop on the first sampled grant matching the class being requested.
    always_comb begin
        pop = '0;
        for (int v = 0; v < 2; v++) begin
            pop[v] = (state[v] == VC_REQ) && !gnt_seen[v] &&
                     ((req_ring_q[v] && gnt_ring[v]) ||
                      (req_pe_q[v] && gnt_pe[v]));
        end
    end

    ring_ibuf_vc_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_W     (FCNT_W)
    ) u_fifo_even (
        .clk  (clk),
        .rst  (rst),
        .push (push[0]),
        .pop  (pop[0]),
        .din  (di),
        .count(count[0]),
        .full (full[0]),
        .head (head[0])
    );

    ring_ibuf_vc_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_W     (FCNT_W)
    ) u_fifo_odd (
        .clk  (clk),
        .rst  (rst),
        .push (push[1]),
        .pop  (pop[1]),
        .din  (di),
        .count(count[1]),
        .full (full[1]),
        .head (head[1])
    );

    // Per-VC request FSMs; head is latched on entry to REQ and held until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < 2; v++) begin
                state[v]  <= VC_IDLE;
                head_q[v] <= '0;
            end
            req_ring_q <= '0;
            req_pe_q   <= '0;
            gnt_seen   <= '0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (!gnt_ring[v] && !gnt_pe[v]) begin
                    gnt_seen[v] <= 1'b0;
                end else if (pop[v]) begin
                    gnt_seen[v] <= 1'b1;
                end
                case (state[v])
                    VC_IDLE, VC_POP: begin
                        if (count[v] != '0) begin
                            state[v]      <= VC_REQ;
                            head_q[v]     <= head[v];
                            req_pe_q[v]   <= hop_is_eject(head[v][HOP_MSB:HOP_LSB]);
                            req_ring_q[v] <= !hop_is_eject(head[v][HOP_MSB:HOP_LSB]);
                        end else begin
                            state[v]      <= VC_IDLE;
                            req_pe_q[v]   <= 1'b0;
                            req_ring_q[v] <= 1'b0;
                        end
                    end
                    VC_REQ: begin
                        if (pop[v]) begin
                            state[v]      <= VC_POP;
                            req_pe_q[v]   <= 1'b0;
                            req_ring_q[v] <= 1'b0;
                        end
                    end
                    default: begin
                        state[v]      <= VC_IDLE;
                        req_pe_q[v]   <= 1'b0;
                        req_ring_q[v] <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ri = polarity ? !full[1] : !full[0];

    assign req_ring_even = req_ring_q[0];
    assign req_ring_odd  = req_ring_q[1];
    assign req_pe_even   = req_pe_q[0];
    assign req_pe_odd    = req_pe_q[1];
    assign data_out_even = head_q[0];
    assign data_out_odd  = head_q[1];

`ifdef RING_IBUF_DROP_CNT_EN
    logic             drop;
    logic [CNT_W-1:0] drop_q;

    assign drop = si && full[in_vc];

    // Saturating count of flits refused because their VC was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_input_vc_buffer.sv
// Directed bench for ring_input_vc_buffer.
// Drop-count expectations follow RING_IBUF_DROP_CNT_EN.
module tb_ring_input_vc_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        polarity;
    logic        si;
    logic        ri;
    logic [63:0] di;
    logic        req_ring_even, req_ring_odd, req_pe_even, req_pe_odd;
    logic        grant_ring_even, grant_ring_odd, grant_pe_even, grant_pe_odd;
    logic [63:0] data_out_even, data_out_odd;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

`ifdef RING_IBUF_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP1 = 8'd1;
    localparam logic [7:0] EXP_DROP2 = 8'd2;
`else
    localparam logic [7:0] EXP_DROP1 = 8'd0;
    localparam logic [7:0] EXP_DROP2 = 8'd0;
`endif

    ring_input_vc_buffer #(
        .DATA_WIDTH(64),
        .DEPTH     (2),
        .CNT_W     (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .polarity       (polarity),
        .si             (si),
        .ri             (ri),
        .di             (di),
        .req_ring_even  (req_ring_even),
        .req_ring_odd   (req_ring_odd),
        .req_pe_even    (req_pe_even),
        .req_pe_odd     (req_pe_odd),
        .grant_ring_even(grant_ring_even),
        .grant_ring_odd (grant_ring_odd),
        .grant_pe_even  (grant_pe_even),
        .grant_pe_odd   (grant_pe_odd),
        .data_out_even  (data_out_even),
        .data_out_odd   (data_out_odd),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mkflit(input logic vc, input logic [7:0] hop,
                                           input logic [15:0] tag);
        return {vc, 1'b0, 6'h00, hop, 32'hA5A5_0000, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        si = 1'b0;
        di = '0;
        grant_ring_even = 1'b0;
        grant_ring_odd  = 1'b0;
        grant_pe_even   = 1'b0;
        grant_pe_odd    = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] reqs;
        rst = 1'b1;
        polarity = 1'b0;
        idle_inputs();
        tick();
        tick();
        reqs = {req_ring_even, req_ring_odd, req_pe_even, req_pe_odd};
        checks++;
        if (reqs !== 4'b0000) begin
            errors++;
            $display("FAIL reset_reqs got %b want %b", reqs, 4'b0000);
        end
        checks++;
        if (data_out_even !== 64'h0 || data_out_odd !== 64'h0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0", data_out_even, data_out_odd);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop got %0d want 0", drop_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (ri !== 1'b1) begin
            errors++;
            $display("FAIL reset_ri got %b want 1", ri);
        end
    endtask

    task automatic test_even_ring();
        logic [63:0] f;
        f = mkflit(1'b0, 8'h04, 16'h0001);
        polarity = 1'b0;
        si = 1'b1;
        di = f;
        tick();
        si = 1'b0;
        checks++;
        if (req_ring_even !== 1'b0) begin
            errors++;
            $display("FAIL even_latency got %b want 0", req_ring_even);
        end
        tick();
        checks++;
        if (req_ring_even !== 1'b1 || req_pe_even !== 1'b0) begin
            errors++;
            $display("FAIL even_req got ring=%b pe=%b want ring=1 pe=0",
                     req_ring_even, req_pe_even);
        end
        checks++;
        if (data_out_even !== f) begin
            errors++;
            $display("FAIL even_data got %h want %h", data_out_even, f);
        end
        grant_ring_even = 1'b1;
        tick();
        grant_ring_even = 1'b0;
        checks++;
        if (req_ring_even !== 1'b0 || ri !== 1'b1) begin
            errors++;
            $display("FAIL even_pop got req=%b ri=%b want req=0 ri=1",
                     req_ring_even, ri);
        end
        tick();
        checks++;
        if (req_ring_even !== 1'b0) begin
            errors++;
            $display("FAIL even_empty got %b want 0", req_ring_even);
        end
    endtask

    task automatic test_odd_pe();
        logic [63:0] f;
        f = mkflit(1'b1, 8'h00, 16'h0002);
        polarity = 1'b1;
        si = 1'b1;
        di = f;
        tick();
        si = 1'b0;
        tick();
        checks++;
        if (req_pe_odd !== 1'b1 || req_ring_odd !== 1'b0) begin
            errors++;
            $display("FAIL odd_req got pe=%b ring=%b want pe=1 ring=0",
                     req_pe_odd, req_ring_odd);
        end
        checks++;
        if (data_out_odd !== f) begin
            errors++;
            $display("FAIL odd_data got %h want %h", data_out_odd, f);
        end
        grant_ring_odd = 1'b1;
        tick();
        grant_ring_odd = 1'b0;
        checks++;
        if (req_pe_odd !== 1'b1) begin
            errors++;
            $display("FAIL odd_wrong_grant got %b want 1", req_pe_odd);
        end
        grant_pe_odd = 1'b1;
        tick();
        grant_pe_odd = 1'b0;
        checks++;
        if (req_pe_odd !== 1'b0) begin
            errors++;
            $display("FAIL odd_pop got %b want 0", req_pe_odd);
        end
        tick();
        checks++;
        if (req_pe_odd !== 1'b0 || req_ring_odd !== 1'b0) begin
            errors++;
            $display("FAIL odd_empty got pe=%b ring=%b want 0", req_pe_odd, req_ring_odd);
        end
    endtask

    task automatic test_full_drop();
        logic [63:0] f1, f2, f3;
        f1 = mkflit(1'b0, 8'h01, 16'h0011);
        f2 = mkflit(1'b0, 8'h02, 16'h0012);
        f3 = mkflit(1'b0, 8'h03, 16'h0013);
        polarity = 1'b0;
        si = 1'b1;
        di = f1;
        tick();
        di = f2;
        tick();
        si = 1'b0;
        checks++;
        if (ri !== 1'b0) begin
            errors++;
            $display("FAIL full_ri_even got %b want 0", ri);
        end
        checks++;
        if (req_ring_even !== 1'b1 || data_out_even !== f1) begin
            errors++;
            $display("FAIL full_head1 got req=%b data=%h want 1/%h",
                     req_ring_even, data_out_even, f1);
        end
        polarity = 1'b1;
        #1;
        checks++;
        if (ri !== 1'b1) begin
            errors++;
            $display("FAIL full_ri_odd got %b want 1", ri);
        end
        polarity = 1'b0;
        si = 1'b1;
        di = f3;
        tick();
        si = 1'b0;
        checks++;
        if (drop_cnt !== EXP_DROP1) begin
            errors++;
            $display("FAIL drop_cnt1 got %0d want %0d", drop_cnt, EXP_DROP1);
        end
        grant_ring_even = 1'b1;
        tick();
        grant_ring_even = 1'b0;
        tick();
        checks++;
        if (req_ring_even !== 1'b1 || data_out_even !== f2) begin
            errors++;
            $display("FAIL full_head2 got req=%b data=%h want 1/%h",
                     req_ring_even, data_out_even, f2);
        end
        grant_ring_even = 1'b1;
        tick();
        grant_ring_even = 1'b0;
        tick();
        checks++;
        if (req_ring_even !== 1'b0 || ri !== 1'b1) begin
            errors++;
            $display("FAIL full_drained got req=%b ri=%b want 0/1", req_ring_even, ri);
        end
        checks++;
        if (data_out_even !== f2) begin
            errors++;
            $display("FAIL full_hold got %h want %h", data_out_even, f2);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] g1, g2, g3;
        g1 = mkflit(1'b0, 8'h10, 16'h0021);
        g2 = mkflit(1'b0, 8'h20, 16'h0022);
        g3 = mkflit(1'b0, 8'h30, 16'h0023);
        polarity = 1'b0;
        si = 1'b1;
        di = g1;
        tick();
        di = g2;
        tick();
        di = g3;
        grant_ring_even = 1'b1;
        tick();
        si = 1'b0;
        checks++;
        if (ri !== 1'b1 || req_ring_even !== 1'b0) begin
            errors++;
            $display("FAIL simul_pop got ri=%b req=%b want 1/0", ri, req_ring_even);
        end
        tick();
        checks++;
        if (req_ring_even !== 1'b1 || data_out_even !== g2) begin
            errors++;
            $display("FAIL simul_head got req=%b data=%h want 1/%h",
                     req_ring_even, data_out_even, g2);
        end
        tick();
        grant_ring_even = 1'b0;
        checks++;
        if (req_ring_even !== 1'b1 || data_out_even !== g2) begin
            errors++;
            $display("FAIL held_grant got req=%b data=%h want 1/%h",
                     req_ring_even, data_out_even, g2);
        end
        tick();
        checks++;
        if (drop_cnt !== EXP_DROP2) begin
            errors++;
            $display("FAIL drop_cnt2 got %0d want %0d", drop_cnt, EXP_DROP2);
        end
        grant_ring_even = 1'b1;
        tick();
        grant_ring_even = 1'b0;
        tick();
        tick();
        checks++;
        if (req_ring_even !== 1'b0 || ri !== 1'b1) begin
            errors++;
            $display("FAIL simul_drained got req=%b ri=%b want 0/1", req_ring_even, ri);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] reqs;
        polarity = 1'b1;
        si = 1'b1;
        di = mkflit(1'b1, 8'h05, 16'h0031);
        tick();
        di = mkflit(1'b1, 8'h06, 16'h0032);
        tick();
        si = 1'b0;
        checks++;
        if (req_ring_odd !== 1'b1) begin
            errors++;
            $display("FAIL mid_req got %b want 1", req_ring_odd);
        end
        rst = 1'b1;
        tick();
        reqs = {req_ring_even, req_ring_odd, req_pe_even, req_pe_odd};
        checks++;
        if (reqs !== 4'b0000 || ri !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got reqs=%b ri=%b want 0000/1", reqs, ri);
        end
        checks++;
        if (drop_cnt !== 8'd0 || data_out_odd !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_state got drop=%0d data=%h want 0/0",
                     drop_cnt, data_out_odd);
        end
        rst = 1'b0;
        tick();
        tick();
        reqs = {req_ring_even, req_ring_odd, req_pe_even, req_pe_odd};
        checks++;
        if (reqs !== 4'b0000) begin
            errors++;
            $display("FAIL mid_after got %b want 0000", reqs);
        end
    endtask

    task automatic test_interleaved();
        logic [63:0] exp_q [2][8];
        int          tx [2];
        int          rx [2];
        int          wt [2];
        logic        gnt_on [2];
        logic        gnt_pe [2];
        logic        rr, rp, want_pe;
        logic [63:0] dout;
        int          v;
        for (int i = 0; i < 8; i++) begin
            exp_q[0][i] = mkflit(1'b0, (i % 3 == 0) ? 8'h00 : 8'(i + 1), 16'(16'h0040 + i));
            exp_q[1][i] = mkflit(1'b1, (i % 2 == 0) ? 8'h00 : 8'(i * 3), 16'(16'h0140 + i));
        end
        for (int k = 0; k < 2; k++) begin
            tx[k] = 0;
            rx[k] = 0;
            wt[k] = int'($urandom_range(0, 5));
            gnt_on[k] = 1'b0;
            gnt_pe[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (rx[0] == 8 && rx[1] == 8 && tx[0] == 8 && tx[1] == 8) break;
            for (int k = 0; k < 2; k++) begin
                rr   = (k == 0) ? req_ring_even : req_ring_odd;
                rp   = (k == 0) ? req_pe_even : req_pe_odd;
                dout = (k == 0) ? data_out_even : data_out_odd;
                if (gnt_on[k]) begin
                    gnt_on[k] = 1'b0;
                end else if (rr || rp) begin
                    if (rx[k] >= 8) begin
                        checks++;
                        errors++;
                        $display("FAIL inter_extra vc=%0d got req with data %h want none",
                                 k, dout);
                        gnt_on[k] = 1'b1;
                        gnt_pe[k] = rp;
                    end else if (wt[k] > 0) begin
                        wt[k]--;
                    end else begin
                        want_pe = (exp_q[k][rx[k]][55:48] == 8'h00);
                        checks++;
                        if (dout !== exp_q[k][rx[k]]) begin
                            errors++;
                            $display("FAIL inter_data vc=%0d idx=%0d got %h want %h",
                                     k, rx[k], dout, exp_q[k][rx[k]]);
                        end
                        checks++;
                        if ({rp, rr} !== {want_pe, !want_pe}) begin
                            errors++;
                            $display("FAIL inter_class vc=%0d idx=%0d got pe=%b ring=%b want pe=%b",
                                     k, rx[k], rp, rr, want_pe);
                        end
                        gnt_on[k] = 1'b1;
                        gnt_pe[k] = want_pe;
                        rx[k]++;
                        wt[k] = int'($urandom_range(0, 5));
                    end
                end
            end
            grant_ring_even = gnt_on[0] && !gnt_pe[0];
            grant_pe_even   = gnt_on[0] && gnt_pe[0];
            grant_ring_odd  = gnt_on[1] && !gnt_pe[1];
            grant_pe_odd    = gnt_on[1] && gnt_pe[1];
            polarity = cyc[0];
            #1;
            v = cyc[0] ? 1 : 0;
            if (tx[v] < 8 && ri === 1'b1) begin
                si = 1'b1;
                di = exp_q[v][tx[v]];
                tx[v]++;
            end else begin
                si = 1'b0;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (rx[0] != 8 || rx[1] != 8) begin
            errors++;
            $display("FAIL inter_count got even=%0d odd=%0d want 8/8", rx[0], rx[1]);
        end
    endtask

    initial begin
        test_reset();
        test_even_ring();
        test_odd_pe();
        test_full_drop();
        test_simultaneous();
        test_reset_mid();
        test_interleaved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
